// File: rtl/dac_sample_packer.sv
// dac_sample_packer: gathers SAMPLE_W-bit samples, one per input beat, into an
// N_LANES-wide word for the DAC bank. Lane 0 sits in the low bits of the word.
// Optional burst padding is enabled by defining DAC_PACKER_PAD_ON_LAST_EN. With
// it, a beat carrying tlast closes the word early and zero-fills the lanes above.
module dac_sample_packer #(
  parameter  int N_LANES  = 16,
  parameter  int SAMPLE_W = 16,
  localparam int OUT_W    = N_LANES * SAMPLE_W,
  localparam int LANE_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [OUT_W-1:0]    m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [31:0]         words_out
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [31:0]       words_q, words_d;
  logic              rdy_q;

  logic              would_complete;
  logic              beat;
  logic              complete;
  logic              handshake;
  logic [OUT_W-1:0]  word;

  // Completion detect and input backpressure. Only a beat that would close a
  // word has to wait for the output register to drain.
  always_comb begin
    would_complete = (lane_q == LANE_W'(N_LANES - 1));
`ifdef DAC_PACKER_PAD_ON_LAST_EN
    would_complete = would_complete | s_axis_tlast;
`endif
    s_axis_tready = rdy_q & ~(would_complete & tvalid_q & ~m_axis_tready);
    beat          = s_axis_tvalid & s_axis_tready;
    complete      = beat & would_complete;
    handshake     = tvalid_q & m_axis_tready;
  end

`ifndef DAC_PACKER_PAD_ON_LAST_EN
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

  // Merge the incoming sample into the partial word. Lanes above the current
  // one are forced to zero, which gives the padding for an early close.
  always_comb begin
    word = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (i < int'(lane_q))
        word[i*SAMPLE_W +: SAMPLE_W] = acc_q[i*SAMPLE_W +: SAMPLE_W];
      else if (i == int'(lane_q))
        word[i*SAMPLE_W +: SAMPLE_W] = s_axis_tdata;
    end
  end

  // Next state: fill lanes, hand a finished word to the output register, and
  // keep tvalid high across a drain that coincides with a new completion.
  always_comb begin
    lane_d   = lane_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    words_d  = words_q + {31'd0, handshake};
    if (complete) begin
      lane_d   = '0;
      acc_d    = '0;
      tdata_d  = word;
      tvalid_d = 1'b1;
`ifdef DAC_PACKER_PAD_ON_LAST_EN
      tlast_d  = s_axis_tlast;
`else
      tlast_d  = 1'b0;
`endif
    end else begin
      if (beat) begin
        lane_d = lane_q + LANE_W'(1);
        acc_d  = word;
      end
      if (handshake) tvalid_d = 1'b0;
    end
  end

  // State registers. rdy_q holds off the input until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q   <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      words_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      words_q  <= words_d;
      rdy_q    <= 1'b1;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign words_out     = words_q;

endmodule

// File: doc/dac_sample_packer.md
DAC_SAMPLE_PACKER -- requirements
Module: dac_sample_packer

Interface
REQ-001 SHALL have parameter N_LANES, default 16, giving the number of samples packed per output word.
REQ-002 SHALL have parameter SAMPLE_W, default 16, giving the bits per sample; output width OUT_W = N_LANES*SAMPLE_W (256 by default).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port s_axis_tdata, input, SAMPLE_W, one sample per beat.
REQ-006 SHALL have port s_axis_tvalid, input, 1, marking the input sample as valid.
REQ-007 SHALL have port s_axis_tready, output, 1, indicating the packer accepts a sample this cycle.
REQ-008 SHALL have port s_axis_tlast, input, 1, marking the final sample of a burst.
REQ-009 SHALL have port m_axis_tdata, output, OUT_W, the packed word feeding the 16-lane DAC bank.
REQ-010 SHALL have port m_axis_tvalid, output, 1, marking the packed word as valid.
REQ-011 SHALL have port m_axis_tready, input, 1, downstream accept.
REQ-012 SHALL have port m_axis_tlast, output, 1, marking the word that closes a burst.
REQ-013 SHALL have port words_out, output, 32, a count of words handed downstream.

Function
REQ-014 SHALL accept a sample only on a cycle where s_axis_tvalid=1 and s_axis_tready=1 (input beat).
REQ-015 SHALL use a lane counter (0..N_LANES-1) and place the sample of an input beat at m_axis_tdata bits [lane*SAMPLE_W +: SAMPLE_W], lane 0 first; the counter increments per beat.
REQ-016 SHALL define a completing beat as an input beat with lane = N_LANES-1 (or as in REQ-027).
REQ-017 SHALL, on a completing beat, load the assembled word into the output register, set m_axis_tvalid=1 on the next cycle, and return lane to 0, giving a latency of 1 cycle from the completing beat to m_axis_tvalid.
REQ-018 SHALL hold m_axis_tdata, m_axis_tvalid and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-019 SHALL clear m_axis_tvalid the cycle after m_axis_tvalid=1 and m_axis_tready=1, unless a completing beat occurs in that same cycle, in which case the new word loads and m_axis_tvalid stays 1 (back-to-back, no bubble).
REQ-020 SHALL drive s_axis_tready=0 only when lane = N_LANES-1, m_axis_tvalid=1 and m_axis_tready=0; otherwise s_axis_tready=1, and lanes 0..N_LANES-2 always fill while output stalls. (This dependence of s_axis_tready on m_axis_tready is combinational.)
REQ-021 SHALL sustain one sample per cycle, i.e. one word every N_LANES cycles, with m_axis_tready held 1.
REQ-022 SHALL increment words_out by 1 on every output handshake, wrapping from 0xFFFFFFFF to 0.
REQ-023 SHALL leave partially filled lanes intact until completed; no timeout flush.

Reset
REQ-024 SHALL, on rst_n=0 asserted at any time including mid-word or mid-stall, immediately clear lane, m_axis_tdata, m_axis_tvalid, m_axis_tlast and words_out to 0 and discard partial data.
REQ-025 SHALL drive s_axis_tready=0 while rst_n=0 and 1 from the first clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL compile burst padding in only when macro DAC_PACKER_PAD_ON_LAST_EN is defined.
REQ-027 SHALL, with the macro defined, also treat an input beat with s_axis_tlast=1 at any lane as completing: lanes above it are zero, m_axis_tlast=1 for that word, lane returns to 0, and the REQ-020 stall condition applies whenever the beat would be completing.
REQ-028 SHALL, without the macro, ignore s_axis_tlast and tie m_axis_tlast to 0.

Verification
REQ-029 SHALL cover a 16-sample stream 0x0001..0x0010 with m_axis_tready=1 -> one word, lane0=0x0001, lane15=0x0010, m_axis_tvalid high the cycle after beat 16, words_out=1.
REQ-030 SHALL cover 64 continuous samples with m_axis_tready=1 -> 4 words, m_axis_tvalid never drops between words, words_out=4.
REQ-031 SHALL cover m_axis_tready=0 with 31 samples offered -> s_axis_tready stays 1 through beat 31, is 0 on beat 32, the first word stays stable, and beat 32 completes the cycle m_axis_tready rises.
REQ-032 SHALL cover rst_n pulsed low after 7 samples -> outputs 0, the next 16 samples form a clean word starting at lane 0.
REQ-033 SHALL cover the macro defined with 5 samples 0xAAAA and tlast on the 5th -> lanes 0-4=0xAAAA, lanes 5-15=0, m_axis_tlast=1; without the macro, no word is emitted.
REQ-034 SHALL cover words_out preloaded to 0xFFFFFFFF via force, plus one word -> words_out=0.
